// File: rtl/uart_tx_fila.sv
// Parametrised UART transmitter with a small transmit FIFO; queued words are sent
// back-to-back, LSB first, with optional parity and one or two stop bits.
module uart_tx_fila #(
    parameter int CLOCKS_POR_BIT    = 87,
    parameter int BITS_DADOS        = 8,
    parameter int PARIDADE          = 0,
    parameter int BITS_PARADA       = 1,
    parameter int PROFUNDIDADE_FIFO = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 haDadosParaTransmitir,
    input  logic [BITS_DADOS-1:0]                byteASerTransmitido,
    output logic                                 filaCheia,
    output logic                                 filaVazia,
    output logic [$clog2(PROFUNDIDADE_FIFO):0]   ocupacaoFila,
    output logic                                 erroEstouro,
    output logic                                 indicaTransmissao,
    output logic                                 bitSerialAtual,
    output logic                                 bitsEstaoEnviados
);

    localparam int LARGURA_CONT = $clog2(CLOCKS_POR_BIT);
    localparam int LARGURA_IDX  = $clog2(BITS_DADOS);
    localparam int LARGURA_PTR  = $clog2(PROFUNDIDADE_FIFO);
    localparam int LARGURA_OCUP = LARGURA_PTR + 1;

    typedef enum logic [2:0] {
        ESPERA,
        INICIO,
        DADOS,
        BIT_PARIDADE,
        PARADA
    } tipoEstado;

    logic [BITS_DADOS-1:0]   memoria [PROFUNDIDADE_FIFO];
    logic [LARGURA_PTR-1:0]  ptrEscrita;
    logic [LARGURA_PTR-1:0]  ptrLeitura;
    logic [LARGURA_OCUP-1:0] ocupacao;
    logic                    escreve;
    logic                    retira;

    tipoEstado               estado;
    tipoEstado               proximoEstado;
    logic [LARGURA_CONT-1:0] contClock;
    logic [LARGURA_IDX-1:0]  indiceBit;
    logic                    indiceParada;
    logic [BITS_DADOS-1:0]   dadoAtual;
    logic [BITS_DADOS-1:0]   palavraCabeca;
    logic                    bitParidade;
    logic                    fimBit;
    logic                    fimQuadro;
    logic                    linhaProxima;

    assign filaCheia         = (ocupacao == LARGURA_OCUP'(PROFUNDIDADE_FIFO));
    assign filaVazia         = (ocupacao == '0);
    assign ocupacaoFila      = ocupacao;
    assign escreve           = haDadosParaTransmitir && !filaCheia;
    assign fimBit            = (contClock == LARGURA_CONT'(CLOCKS_POR_BIT - 1));
    assign indicaTransmissao = (estado != ESPERA);
    assign palavraCabeca     = memoria[ptrLeitura];

    // NOTE: storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (escreve) begin
            memoria[ptrEscrita] <= byteASerTransmitido;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        proximoEstado = estado;
        retira        = 1'b0;
        fimQuadro     = 1'b0;
        case (estado)
            ESPERA: begin
                if (!filaVazia) begin
                    retira        = 1'b1;
                    proximoEstado = INICIO;
                end
            end
            INICIO: begin
                if (fimBit) proximoEstado = DADOS;
            end
            DADOS: begin
                if (fimBit && indiceBit == LARGURA_IDX'(BITS_DADOS - 1)) begin
                    proximoEstado = (PARIDADE != 0) ? BIT_PARIDADE : PARADA;
                end
            end
            BIT_PARIDADE: begin
                if (fimBit) proximoEstado = PARADA;
            end
            PARADA: begin
                if (fimBit && indiceParada == 1'(BITS_PARADA - 1)) begin
                    fimQuadro = 1'b1;
                    if (!filaVazia) begin
                        retira        = 1'b1;
                        proximoEstado = INICIO;
                    end else begin
                        proximoEstado = ESPERA;
                    end
                end
            end
            default: proximoEstado = ESPERA;
        endcase
    end

    // Line level for the current state; registered below, so the pin lags the state by one cycle.
    always_comb begin
        linhaProxima = 1'b1;
        case (estado)
            INICIO:       linhaProxima = 1'b0;
            DADOS:        linhaProxima = dadoAtual[indiceBit];
            BIT_PARIDADE: linhaProxima = bitParidade;
            default:      linhaProxima = 1'b1;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado            <= ESPERA;
            ptrEscrita        <= '0;
            ptrLeitura        <= '0;
            ocupacao          <= '0;
            contClock         <= '0;
            indiceBit         <= '0;
            indiceParada      <= 1'b0;
            dadoAtual         <= '0;
            bitParidade       <= 1'b0;
            bitSerialAtual    <= 1'b1;
            bitsEstaoEnviados <= 1'b0;
            erroEstouro       <= 1'b0;
        end else begin
            estado            <= proximoEstado;
            bitSerialAtual    <= linhaProxima;
            bitsEstaoEnviados <= fimQuadro;
            erroEstouro       <= haDadosParaTransmitir && filaCheia;

            if (escreve) ptrEscrita <= ptrEscrita + LARGURA_PTR'(1);
            if (retira) begin
                ptrLeitura  <= ptrLeitura + LARGURA_PTR'(1);
                dadoAtual   <= palavraCabeca;
                bitParidade <= (PARIDADE == 1) ? ~^palavraCabeca : ^palavraCabeca;
            end

            case ({escreve, retira})
                2'b10:   ocupacao <= ocupacao + LARGURA_OCUP'(1);
                2'b01:   ocupacao <= ocupacao - LARGURA_OCUP'(1);
                default: ocupacao <= ocupacao;
            endcase

            // Bit timing restarts with every popped word, so back-to-back frames begin cleanly.
            if (estado == ESPERA || retira) begin
                contClock    <= '0;
                indiceBit    <= '0;
                indiceParada <= 1'b0;
            end else begin
                contClock <= fimBit ? '0 : contClock + LARGURA_CONT'(1);
                if (fimBit && estado == DADOS && indiceBit != LARGURA_IDX'(BITS_DADOS - 1)) begin
                    indiceBit <= indiceBit + LARGURA_IDX'(1);
                end
                if (fimBit && estado == PARADA && indiceParada != 1'(BITS_PARADA - 1)) begin
                    indiceParada <= indiceParada + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fila.sv
// Bench for uart_tx_fila: three configurations checked cycle by cycle against an
// event-level model (word queue plus frame bit lists built from the framing rules).
module tb_uart_tx_fila;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int ND [3] = '{8, 7, 7};
    localparam int PAR[3] = '{0, 2, 1};
    localparam int NS [3] = '{1, 2, 1};

    typedef struct {
        logic       wr;
        logic [8:0] din;
        logic       expLine;
        logic       expBusy;
        logic       expDone;
        logic       expErr;
        logic       expFull;
        logic       expEmpty;
        int         expOcc;
    } vec_t;

    typedef struct {
        int         row;
        logic [8:0] d;
    } wr_t;

    logic clock;
    logic reset;

    logic       wrA, cheiaA, vaziaA, erroA, ocupadoA, linhaA, fimA;
    logic [7:0] dA;
    logic [2:0] ocupA;
    logic       wrB, cheiaB, vaziaB, erroB, ocupadoB, linhaB, fimB;
    logic [6:0] dB;
    logic [2:0] ocupB;
    logic       wrC, cheiaC, vaziaC, erroC, ocupadoC, linhaC, fimC;
    logic [6:0] dC;
    logic [2:0] ocupC;

    int   inst;
    logic sLinha, sBusy, sDone, sErr, sFull, sEmpty;
    logic [2:0] sOcc;

    vec_t tbl[1024];
    wr_t  writes[$];

    int nCompared;
    int nMismatched;

    uart_tx_fila #(.CLOCKS_POR_BIT(CPB), .BITS_DADOS(8), .PARIDADE(0), .BITS_PARADA(1),
                   .PROFUNDIDADE_FIFO(DEPTH)) dutA (
        .clock(clock), .reset(reset), .haDadosParaTransmitir(wrA), .byteASerTransmitido(dA),
        .filaCheia(cheiaA), .filaVazia(vaziaA), .ocupacaoFila(ocupA), .erroEstouro(erroA),
        .indicaTransmissao(ocupadoA), .bitSerialAtual(linhaA), .bitsEstaoEnviados(fimA));

    uart_tx_fila #(.CLOCKS_POR_BIT(CPB), .BITS_DADOS(7), .PARIDADE(2), .BITS_PARADA(2),
                   .PROFUNDIDADE_FIFO(DEPTH)) dutB (
        .clock(clock), .reset(reset), .haDadosParaTransmitir(wrB), .byteASerTransmitido(dB),
        .filaCheia(cheiaB), .filaVazia(vaziaB), .ocupacaoFila(ocupB), .erroEstouro(erroB),
        .indicaTransmissao(ocupadoB), .bitSerialAtual(linhaB), .bitsEstaoEnviados(fimB));

    uart_tx_fila #(.CLOCKS_POR_BIT(CPB), .BITS_DADOS(7), .PARIDADE(1), .BITS_PARADA(1),
                   .PROFUNDIDADE_FIFO(DEPTH)) dutC (
        .clock(clock), .reset(reset), .haDadosParaTransmitir(wrC), .byteASerTransmitido(dC),
        .filaCheia(cheiaC), .filaVazia(vaziaC), .ocupacaoFila(ocupC), .erroEstouro(erroC),
        .indicaTransmissao(ocupadoC), .bitSerialAtual(linhaC), .bitsEstaoEnviados(fimC));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        case (inst)
            1: {sLinha, sBusy, sDone, sErr, sFull, sEmpty, sOcc} =
                   {linhaB, ocupadoB, fimB, erroB, cheiaB, vaziaB, ocupB};
            2: {sLinha, sBusy, sDone, sErr, sFull, sEmpty, sOcc} =
                   {linhaC, ocupadoC, fimC, erroC, cheiaC, vaziaC, ocupC};
            default: {sLinha, sBusy, sDone, sErr, sFull, sEmpty, sOcc} =
                   {linhaA, ocupadoA, fimA, erroA, cheiaA, vaziaA, ocupA};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int i, input logic wr, input logic [8:0] d);
        wrA = 1'b0;
        wrB = 1'b0;
        wrC = 1'b0;
        case (i)
            1:       begin wrB = wr; dB = d[6:0]; end
            2:       begin wrC = wr; dC = d[6:0]; end
            default: begin wrA = wr; dA = d[7:0]; end
        endcase
    endtask

    // Serial frame for word w: start 0, data LSB first, optional parity, stop bits at 1.
    function automatic void buildFrame(input int i, input logic [8:0] w,
                                       output logic [15:0] fb, output int len);
        int ones;
        fb   = '1;
        len  = 0;
        ones = 0;
        fb[len] = 1'b0;
        len++;
        for (int b = 0; b < ND[i]; b++) begin
            fb[len] = w[b];
            ones += int'(w[b]);
            len++;
        end
        if (PAR[i] != 0) begin
            fb[len] = (PAR[i] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            len++;
        end
        for (int s = 0; s < NS[i]; s++) begin
            fb[len] = 1'b1;
            len++;
        end
    endfunction

    // Fills the vector table from the write list, then applies it one row per clock.
    task automatic runScenario(input string tag, input int i);
        logic [8:0]  fifo[$];
        logic [8:0]  w;
        logic [8:0]  mask;
        logic [15:0] bits;
        int          len, frameLen, fs, fend, nRows;
        logic        active, lineNext, full, doneNow, popNow;

        mask = 9'((1 << ND[i]) - 1);
        buildFrame(i, 9'd0, bits, len);
        frameLen = len * CPB;
        nRows = writes[writes.size() - 1].row + 1 + (writes.size() + 1) * frameLen + 4;
        if (nRows > 1024) nRows = 1024;
        active   = 1'b0;
        lineNext = 1'b1;
        fs       = 0;
        fend     = 0;

        for (int e = 0; e < nRows; e++) begin
            tbl[e].wr  = 1'b0;
            tbl[e].din = '0;
            foreach (writes[k]) begin
                if (writes[k].row == e) begin
                    tbl[e].wr  = 1'b1;
                    tbl[e].din = writes[k].d & mask;
                end
            end
            full    = (fifo.size() == DEPTH);
            doneNow = active && (e == fend);
            popNow  = (fifo.size() > 0) && (!active || doneNow);
            if (popNow) begin
                w = fifo.pop_front();
                buildFrame(i, w, bits, len);
                fs     = e;
                fend   = e + frameLen;
                active = 1'b1;
            end else if (doneNow) begin
                active = 1'b0;
            end
            if (tbl[e].wr && !full) fifo.push_back(tbl[e].din);
            tbl[e].expErr   = tbl[e].wr && full;
            tbl[e].expLine  = lineNext;
            lineNext        = active ? bits[(e - fs) / CPB] : 1'b1;
            tbl[e].expBusy  = active;
            tbl[e].expDone  = doneNow;
            tbl[e].expOcc   = fifo.size();
            tbl[e].expFull  = (fifo.size() == DEPTH);
            tbl[e].expEmpty = (fifo.size() == 0);
        end

        inst = i;
        for (int e = 0; e < nRows; e++) begin
            drive(i, tbl[e].wr, tbl[e].din);
            @(negedge clock);
            check($sformatf("%s[%0d] linha", tag, e), 32'(sLinha), 32'(tbl[e].expLine));
            check($sformatf("%s[%0d] transmite", tag, e), 32'(sBusy), 32'(tbl[e].expBusy));
            check($sformatf("%s[%0d] enviado", tag, e), 32'(sDone), 32'(tbl[e].expDone));
            check($sformatf("%s[%0d] estouro", tag, e), 32'(sErr), 32'(tbl[e].expErr));
            check($sformatf("%s[%0d] cheia", tag, e), 32'(sFull), 32'(tbl[e].expFull));
            check($sformatf("%s[%0d] vazia", tag, e), 32'(sEmpty), 32'(tbl[e].expEmpty));
            check($sformatf("%s[%0d] ocupacao", tag, e), 32'(sOcc), 32'(tbl[e].expOcc));
        end
        drive(i, 1'b0, 9'd0);
    endtask

    task automatic checkIdle(input string tag, input int i);
        inst = i;
        #1;
        check({tag, " linha"}, 32'(sLinha), 32'd1);
        check({tag, " transmite"}, 32'(sBusy), 32'd0);
        check({tag, " enviado"}, 32'(sDone), 32'd0);
        check({tag, " estouro"}, 32'(sErr), 32'd0);
        check({tag, " cheia"}, 32'(sFull), 32'd0);
        check({tag, " vazia"}, 32'(sEmpty), 32'd1);
        check({tag, " ocupacao"}, 32'(sOcc), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   row;
        int   badCycles;
        logic [8:0] w;

        nCompared   = 0;
        nMismatched = 0;
        inst  = 0;
        reset = 1'b1;
        wrA = 1'b0; wrB = 1'b0; wrC = 1'b0;
        dA  = '0;   dB  = '0;   dC  = '0;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) checkIdle($sformatf("reset%0d", i), i);
        reset = 1'b0;
        @(negedge clock);

        // Single 8N1 frame of 0xA5.
        writes.delete();
        writes.push_back('{0, 9'h0A5});
        runScenario("a5", 0);

        // Seven data bits with even and then odd parity.
        runScenario("par_even", 1);
        runScenario("par_odd", 2);

        // Two stop bits, back-to-back frames.
        writes.delete();
        writes.push_back('{0, 9'h000});
        writes.push_back('{1, 9'h07F});
        runScenario("stop2", 1);

        // Six consecutive writes: five accepted, the sixth overflows.
        writes.delete();
        for (int k = 0; k < 6; k++) writes.push_back('{k, 9'(8'h11 * (k + 1))});
        runScenario("estouro", 0);

        // Write coinciding with the pop at the end of the first frame, occupancy 2.
        writes.delete();
        writes.push_back('{0, 9'h0C3});
        writes.push_back('{1, 9'h081});
        writes.push_back('{2, 9'h07E});
        writes.push_back('{1 + 10 * CPB, 9'h055});
        runScenario("simult", 0);

        // Reset pulse while data bit 3 is on the line.
        inst = 0;
        w = 9'h03C;
        drive(0, 1'b1, w);
        @(negedge clock);
        drive(0, 1'b0, 9'd0);
        repeat (18) @(negedge clock);
        check("abort pre linha", 32'(sLinha), 32'(w[3]));
        check("abort pre transmite", 32'(sBusy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort linha", 32'(sLinha), 32'd1);
        check("abort transmite", 32'(sBusy), 32'd0);
        check("abort ocupacao", 32'(sOcc), 32'd0);
        check("abort vazia", 32'(sEmpty), 32'd1);
        check("abort enviado", 32'(sDone), 32'd0);
        badCycles = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (sDone !== 1'b0 || sLinha !== 1'b1 || sBusy !== 1'b0) badCycles++;
        end
        check("abort quiet cycles", 32'(badCycles), 32'd0);
        writes.delete();
        writes.push_back('{0, 9'h05A});
        runScenario("apos_abort", 0);

        // Random words and write spacing on every configuration.
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 4; r++) begin
                writes.delete();
                row = 0;
                for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                    writes.push_back('{row, 9'($urandom)});
                    row += ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                       : int'($urandom_range(1, 3));
                end
                runScenario($sformatf("rand%0d_%0d", i, r), i);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
